// File: rtl/bram_loader_pkg.sv
// rtl/bram_loader_pkg.sv - shared defaults and FSM encoding for the BRAM row loader
package bram_loader_pkg;

    localparam int ABITS_DEF = 8;
    localparam int DBITS_DEF = 512;
    localparam int WBITS_DEF = 32;
    localparam int WPR_DEF   = DBITS_DEF / WBITS_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/row_packer.sv
// rtl/row_packer.sv - packs stream words into one BRAM row, low word first, zero-filled
// Optional byte reversal of each word when BRAM_LOADER_BSWAP_EN is defined.
module row_packer
    import bram_loader_pkg::*;
#(
    parameter int DBITS = DBITS_DEF,
    parameter int WBITS = WBITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             acc_i,
    input  logic             last_i,
    input  logic [WBITS-1:0] data_i,
    output logic             full_o,
    output logic [DBITS-1:0] row_o
);
    localparam int WPR = DBITS / WBITS;
    localparam int CW  = (WPR > 1) ? $clog2(WPR) : 1;

    logic [DBITS-1:0] row_q, row_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WBITS-1:0] word;

`ifdef BRAM_LOADER_BSWAP_EN
    always_comb begin
        word = '0;
        for (int b = 0; b < WBITS / 8; b++) begin
            word[b*8 +: 8] = data_i[WBITS-8-b*8 +: 8];
        end
    end
`else
    assign word = data_i;
`endif

    assign full_o = acc_i && (cnt_q == CW'(WPR - 1));

    // row_o already contains the word being accepted this cycle
    always_comb begin
        row_o = row_q;
        row_o[int'(cnt_q) * WBITS +: WBITS] = word;
    end

    always_comb begin
        row_d = row_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            row_d = '0;
            cnt_d = '0;
        end else if (acc_i) begin
            if (full_o || last_i) begin
                row_d = '0;
                cnt_d = '0;
            end else begin
                row_d = row_o;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            cnt_q <= '0;
        end else begin
            row_q <= row_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bram_loader.sv
// rtl/bram_loader.sv - loads a word stream into consecutive BRAM rows, then pulses start
// Define BRAM_LOADER_BSWAP_EN to byte-reverse every accepted word.
module bram_loader
    import bram_loader_pkg::*;
#(
    parameter int ABITS = ABITS_DEF,
    parameter int DBITS = DBITS_DEF,
    parameter int WBITS = WBITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req,
    input  logic [ABITS-1:0] base_addr,
    input  logic [ABITS-1:0] num_rows,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WBITS-1:0] s_data,
    input  logic             s_last,
    output logic [ABITS-1:0] wr_addr2,
    output logic [DBITS-1:0] wr_data2,
    output logic             wr_en2,
    output logic             busy,
    output logic             start,
    output logic             err
);
    state_t           state_q, state_d;
    logic [ABITS-1:0] base_q, base_d, wr_addr_q, wr_addr_d;
    logic [ABITS:0]   rows_q, rows_d, row_cnt_q, row_cnt_d, rows_written;
    logic             last_seen_q, last_seen_d, row_full_q, row_full_d, err_q, err_d;
    logic [DBITS-1:0] wr_data_q, wr_data_d, row_next;
    logic             load, accept, word_full, row_done, final_row;

    assign load         = (state_q == IDLE) && load_req;
    assign accept       = (state_q == FILL) && s_valid;
    assign row_done     = accept && (word_full || s_last);
    assign rows_written = row_cnt_q + 1'b1;
    assign final_row    = (rows_written == rows_q);

    row_packer #(
        .DBITS (DBITS),
        .WBITS (WBITS)
    ) u_row_packer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (load),
        .acc_i  (accept),
        .last_i (s_last),
        .data_i (s_data),
        .full_o (word_full),
        .row_o  (row_next)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        rows_d      = rows_q;
        row_cnt_d   = row_cnt_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        last_seen_d = last_seen_q;
        row_full_d  = row_full_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d     = FILL;
                    base_d      = base_addr;
                    rows_d      = (num_rows == '0) ? {1'b1, {ABITS{1'b0}}} : {1'b0, num_rows};
                    row_cnt_d   = '0;
                    last_seen_d = 1'b0;
                    row_full_d  = 1'b0;
                    err_d       = 1'b0;
                end
            end
            FILL: begin
                if (row_done) begin
                    state_d     = WRITE;
                    wr_addr_d   = base_q + row_cnt_q[ABITS-1:0];
                    wr_data_d   = row_next;
                    last_seen_d = s_last;
                    row_full_d  = word_full;
                end
            end
            WRITE: begin
                row_cnt_d = rows_written;
                if (final_row || last_seen_q) begin
                    state_d = DONE;
                    // a short final row is a length mismatch too
                    err_d   = !(final_row && last_seen_q && row_full_q);
                end else begin
                    state_d = FILL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            rows_q      <= '0;
            row_cnt_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            last_seen_q <= 1'b0;
            row_full_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            rows_q      <= rows_d;
            row_cnt_q   <= row_cnt_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            last_seen_q <= last_seen_d;
            row_full_q  <= row_full_d;
            err_q       <= err_d;
        end
    end

    assign s_ready  = (state_q == FILL);
    assign wr_en2   = (state_q == WRITE);
    assign busy     = (state_q == FILL) || (state_q == WRITE);
    assign start    = (state_q == DONE);
    assign err      = err_q;
    assign wr_addr2 = wr_addr_q;
    assign wr_data2 = wr_data_q;

endmodule

// File: doc/bram_loader.md
BRAM_LOADER -- requirements
Module: bram_loader

Interface
REQ-001 SHALL have parameter ABITS, default 8, meaning BRAM address width.
REQ-002 SHALL have parameter DBITS, default 512, meaning BRAM row width.
REQ-003 SHALL have parameter WBITS, default 32, meaning stream word width; DBITS SHALL be a multiple of WBITS, and WPR = DBITS/WBITS (default 16) words per row.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. Reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port load_req, input, 1 bit: a one-cycle pulse that starts a load.
REQ-007 SHALL have port base_addr, input, ABITS bits: first row address, sampled on load_req.
REQ-008 SHALL have port num_rows, input, ABITS bits: rows to write, sampled on load_req; 0 means 2^ABITS rows.
REQ-009 SHALL have port s_valid, input, 1 bit: stream word valid.
REQ-010 SHALL have port s_ready, output, 1 bit: stream word accepted when s_valid and s_ready are both high.
REQ-011 SHALL have port s_data, input, WBITS bits: stream word.
REQ-012 SHALL have port s_last, input, 1 bit: marks the final word of the operand stream.
REQ-013 SHALL have ports wr_addr2 (output, ABITS), wr_data2 (output, DBITS) and wr_en2 (output, 1): BRAM write port 2.
REQ-014 SHALL have port busy, output, 1 bit: high while in FILL or WRITE.
REQ-015 SHALL have port start, output, 1 bit: one-cycle pulse to the exponentiator when the load completes.
REQ-016 SHALL have port err, output, 1 bit: sticky flag for a length mismatch; cleared on load_req.

Function
REQ-017 The FSM SHALL have the states IDLE, FILL, WRITE and DONE.
REQ-018 IDLE->FILL on load_req.
- Latch base_addr and num_rows; clear the word counter, row counter and err.
- load_req outside IDLE SHALL be ignored.
REQ-019 FILL: s_ready=1.
- The k-th accepted word in a row SHALL be placed at bits [k*WBITS +: WBITS]; word 0 is least significant.
REQ-020 FILL->WRITE on the cycle the WPR-th word of a row is accepted, or on the cycle a word with s_last is accepted.
- Unfilled word slots SHALL be zero.
REQ-021 WRITE: exactly one cycle.
- wr_en2=1, wr_addr2 = base + row_count (mod 2^ABITS, wraps), wr_data2 = packed row.
- s_ready=0.
REQ-022 WRITE->FILL when rows written < num_rows and no s_last has been seen.
REQ-023 WRITE->DONE when rows written == num_rows or s_last has been seen.
- err=1 if the two conditions disagree: s_last on a row before the final row, or the final row completed without s_last.
REQ-024 DONE: start=1 for one cycle, then go to IDLE.
REQ-025 Latency: wr_en2 SHALL assert the cycle after the accepting handshake of the last word of a row; start SHALL assert the cycle after the final WRITE.
REQ-026 s_valid with s_ready low SHALL NOT be consumed; s_data is ignored when s_valid=0.
REQ-027 Outside WRITE: wr_en2=0 and wr_data2 holds its last value.

Reset
REQ-028 rst SHALL force IDLE on the next edge, including mid-load.
- s_ready=0, wr_en2=0, start=0, busy=0, err=0, wr_addr2=0, wr_data2=0, counters=0.
- A row partially packed at reset SHALL be discarded and never written.

Configuration
REQ-029 With BRAM_LOADER_BSWAP_EN defined, each accepted s_data word SHALL be byte-reversed before packing (input 32'h11223344 stored as 32'h44332211).
- Without the macro, words SHALL be stored unmodified.
- The macro SHALL NOT change timing.

Structure
REQ-030 The shared package SHALL hold:
- the ABITS, DBITS and WBITS defaults;
- WPR;
- the state encoding typedef (IDLE=0, FILL=1, WRITE=2, DONE=3).
REQ-031 The block SHALL use one sub-module, row_packer: the word shift/pack register with byte-swap option, word counter and zero-fill. The FSM stays in bram_loader.

Verification
REQ-032 Basic load: load_req, base=8'h10, num_rows=2, 32 back-to-back words 0..31 with s_last on word 31.
- Expected: two wr_en2 pulses at 0x10 and 0x11; row 0 bits[31:0]=0 and bits[511:480]=15.
- start one cycle after the second write; err=0.
REQ-033 Backpressure and gaps: s_valid toggling 1/0 randomly.
- Expected: identical BRAM contents to REQ-032; no word dropped or duplicated; s_ready=0 during each WRITE.
REQ-034 Short stream: num_rows=2, s_last on word 20.
- Expected: row 1 has words 16..20 and zeros above bit 159; err=1; start pulses.
REQ-035 Address wrap: base=8'hFF, num_rows=2.
- Expected: writes at 0xFF, then 0x00.
REQ-036 Reset mid-load: rst asserted after 10 words of row 0.
- Expected: no wr_en2 pulse; all outputs 0 next cycle.
- A new load then completes normally.
REQ-037 Byte swap: with BRAM_LOADER_BSWAP_EN, word 32'h11223344 reads back as 32'h44332211 in slot 0.
